// File: rtl/uart_tx_arbiter_if.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundles the requester-side and transmitter-side handshake signals of
//   uart_tx_arbiter so the arbiter and its environment share one definition.
//
//   Parameters:
//     NUM_REQ     number of byte-stream requesters
//     WORD_WIDTH  byte width (matches the UART transmitter)
//
//   Signals:
//     req_valid   [NUM_REQ]             per-requester byte valid
//     req_data    [NUM_REQ*WORD_WIDTH]  flattened bytes, requester i at
//                                       [i*WORD_WIDTH +: WORD_WIDTH]
//     req_last    [NUM_REQ]             final byte of a packet
//     req_ready   [NUM_REQ]             per-requester accept
//     tx_valid                          byte valid to the transmitter
//     tx_data     [WORD_WIDTH]          byte to the transmitter
//     tx_ready                          transmitter can accept a byte
//     grant       [NUM_REQ]             one-hot current owner
//     busy                              arbiter in GRANT or GAP
//     timeout_err                       one-cycle pulse on forced release
//
//   Modports:
//     slave   the arbiter side
//     master  the requesters + transmitter side
// ----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WORD_WIDTH = 8
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*WORD_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          tx_valid;
  logic [WORD_WIDTH-1:0]         tx_data;
  logic                          tx_ready;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;
  logic                          timeout_err;

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    input  tx_ready,
    output req_ready,
    output tx_valid,
    output tx_data,
    output grant,
    output busy,
    output timeout_err
  );

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    output tx_ready,
    input  req_ready,
    input  tx_valid,
    input  tx_data,
    input  grant,
    input  busy,
    input  timeout_err
  );

endinterface

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//   Round-robin arbiter sharing one UART transmitter between NUM_REQ
//   byte-stream requesters. The line is granted for a whole packet (through
//   the byte flagged req_last) so packets never interleave, and a programmable
//   idle gap is enforced after each packet before re-arbitrating.
//
//   Parameters:
//     NUM_REQ         number of requesters (>= 2)
//     WORD_WIDTH      byte width
//     GAP_CYCLES      idle cycles after a packet's last byte (0 allowed)
//     TIMEOUT_CYCLES  stall limit for the owner (timeout build only, >= 1)
//
//   Ports:
//     clock   single clock
//     rst     asynchronous, active-high reset
//     bus     uart_tx_arbiter_if.slave: requester handshakes, transmitter
//             handshake, grant / busy / timeout_err status
//
//   Optional feature:
//     UART_TX_ARB_TIMEOUT_EN  when defined, an owner that holds the grant
//                             with req_valid low for TIMEOUT_CYCLES cycles is
//                             released straight to IDLE and timeout_err
//                             pulses. When undefined the grant is held until
//                             the last byte is transferred and timeout_err=0.
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned WORD_WIDTH     = 8,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clock,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int unsigned PW = $clog2(NUM_REQ);
  localparam int unsigned GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [PW:0]   NREQ_W   = (PW + 1)'(NUM_REQ);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [PW-1:0]      r_ptr;
  logic [NUM_REQ-1:0] r_grant;
  logic [GW-1:0]      r_gap_cnt;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int unsigned SW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT_CYCLES - 1);

  logic [SW-1:0]      r_stall_cnt;
  logic               r_timeout_err;
`else
  logic               w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  // --------------------------------------------------------------------------
  // Round-robin pick: rotate the request vector so bit 0 corresponds to ptr,
  // take the lowest set bit, then rotate the offset back to a real index.
  // --------------------------------------------------------------------------
  logic [NUM_REQ-1:0] w_rot;
  logic               w_any;
  logic [PW-1:0]      w_off;
  logic [PW:0]        w_sum;
  logic [PW-1:0]      w_win_idx;
  logic [PW:0]        w_inc;
  logic [PW-1:0]      w_ptr_next;
  logic [NUM_REQ-1:0] w_win_oh;

  assign w_rot = NUM_REQ'({bus.req_valid, bus.req_valid} >> r_ptr);

  always_comb begin
    w_any = 1'b0;
    w_off = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_any && w_rot[k]) begin
        w_any = 1'b1;
        w_off = PW'(k);
      end
    end
  end

  assign w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_win_idx  = (w_sum >= NREQ_W) ? PW'(w_sum - NREQ_W) : w_sum[PW-1:0];
  assign w_inc      = {1'b0, w_win_idx} + (PW + 1)'(1);
  assign w_ptr_next = (w_inc == NREQ_W) ? '0 : w_inc[PW-1:0];
  assign w_win_oh   = {{(NUM_REQ - 1){1'b0}}, 1'b1} << w_win_idx;

  // --------------------------------------------------------------------------
  // Datapath mux. r_grant is non-zero only in GRANT, so every output below
  // collapses to zero in IDLE and GAP without an explicit state decode.
  // --------------------------------------------------------------------------
  logic                  w_tx_valid;
  logic                  w_tx_last;
  logic [WORD_WIDTH-1:0] w_tx_data;
  logic                  w_xfer;

  assign w_tx_valid = |(r_grant & bus.req_valid);
  assign w_tx_last  = |(r_grant & bus.req_last);

  always_comb begin
    w_tx_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_tx_data = bus.req_data[i*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  assign w_xfer = (r_state == S_GRANT) && w_tx_valid && bus.tx_ready;

  assign bus.tx_valid  = w_tx_valid;
  assign bus.tx_data   = w_tx_data;
  assign bus.req_ready = r_grant & {NUM_REQ{bus.tx_ready}};
  assign bus.grant     = r_grant;
  assign bus.busy      = (r_state != S_IDLE);

`ifdef UART_TX_ARB_TIMEOUT_EN
  assign bus.timeout_err = r_timeout_err;
`else
  assign bus.timeout_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_grant       <= '0;
      r_gap_cnt     <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      r_stall_cnt   <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
      r_timeout_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_GRANT;
            r_grant <= w_win_oh;
            r_ptr   <= w_ptr_next;
          end
        end

        S_GRANT: begin
          if (w_xfer && w_tx_last) begin
            r_grant   <= '0;
            r_gap_cnt <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            r_stall_cnt <= '0;
`endif
            if (GAP_CYCLES == 0) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_GAP;
            end
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (w_tx_valid) begin
            r_stall_cnt <= '0;
          end else if (r_stall_cnt == STALL_LAST) begin
            // The stalled cycle that would bring the count to TIMEOUT_CYCLES
            // releases the line; ptr already points past this owner.
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_stall_cnt   <= '0;
            r_timeout_err <= 1'b1;
          end else begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
          end
`endif
        end

        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter between `NUM_REQ` byte-stream requesters, granting the line for a whole packet (up to and including the byte flagged `req_last`) so that packets from different sources never interleave on the wire. It sits directly upstream of the UART TX block. Its `tx_valid`/`tx_data` outputs drive the transmitter's data-valid/data inputs, and the transmitter's ready output feeds `tx_ready`. After each packet it enforces a programmable idle gap before re-arbitrating.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `WORD_WIDTH`, 8: byte width; matches the transmitter.
- `GAP_CYCLES`, 16: clock cycles of enforced idle after a packet's last byte is accepted; 0 allowed.
- `TIMEOUT_CYCLES`, 1024: stall limit for the granted requester, used only with the timeout feature; ≥1.
- `clock`, in, 1: single clock.
- `rst`, in, 1: reset, asynchronous and active-high.
- `req_valid`, in, NUM_REQ: per-requester byte valid.
- `req_data`, in, NUM_REQ*WORD_WIDTH: flattened bytes; requester i occupies `[i*WORD_WIDTH +: WORD_WIDTH]`.
- `req_last`, in, NUM_REQ: marks the final byte of a packet; qualified by the transfer.
- `req_ready`, out, NUM_REQ: per-requester accept.
- `tx_valid`, out, 1: byte valid to the transmitter.
- `tx_data`, out, WORD_WIDTH: byte to the transmitter.
- `tx_ready`, in, 1: transmitter can accept a byte.
- `grant`, out, NUM_REQ: one-hot current owner; all zero when no owner.
- `busy`, out, 1: high in GRANT or GAP.
- `timeout_err`, out, 1: one-cycle pulse on forced release; tied 0 when the feature is compiled out.

## Operation
- A transfer occurs when `tx_valid && tx_ready` in GRANT. The transmitter captures the byte on that edge.
- **States:** IDLE, GRANT, GAP.
- **IDLE:**
  - `grant`=0, `tx_valid`=0, `req_ready`=0.
  - If any `req_valid` is high, pick the first set bit scanning from `ptr` upward, modulo NUM_REQ.
  - Register `grant` and go to GRANT. Set `ptr` to the winner index + 1, modulo NUM_REQ.
- **GRANT (owner g):**
  - `tx_valid`=`req_valid[g]`, `tx_data`=`req_data[g]`, `req_ready[g]`=`tx_ready`. All other `req_ready` are 0.
  - Transfer with `req_last[g]`=1: go to GAP, or to IDLE if `GAP_CYCLES`=0.
  - Transfer with `req_last[g]`=0: stay in GRANT.
  - Owner deasserting `req_valid` mid-packet: grant is held, `tx_valid`=0.
- **GAP:**
  - Gap counter loads 0 on entry and increments each cycle. Exit to IDLE when it reaches `GAP_CYCLES`-1.
  - Outputs are as in IDLE except `busy`=1.
  - Requests arriving in GAP wait; they are not lost and not granted early.
- **Round-robin:** `ptr` resets to 0. Ties are resolved purely by `ptr`. With all requesters valid, grant order is 0,1,2,…,NUM_REQ-1,0.
- **Widths:**
  - `ptr` and owner index are `$clog2(NUM_REQ)` bits.
  - Gap counter is `$clog2(GAP_CYCLES+1)` bits (minimum 1).
  - Stall counter is `$clog2(TIMEOUT_CYCLES+1)` bits.
  - No counter wraps; each is cleared on state exit.
- **Reset (asynchronous, any time including mid-packet):**
  - State IDLE; `ptr`, `grant`, all counters = 0.
  - `tx_valid`, `req_ready`, `busy`, `timeout_err` = 0; `tx_data` = 0.
  - Partial packets are abandoned. The requester must restart its packet.

## Timing
- Arbitration latency is 1 cycle: a request seen in IDLE at edge N gives `grant` and `tx_valid` from cycle N+1.
- `tx_valid`, `tx_data` and `req_ready` are combinational from the registered grant. There is no added byte latency in GRANT.
- The last-byte transfer at edge M gives GAP from cycle M+1. IDLE is reached at cycle M+1+`GAP_CYCLES`, and the earliest next grant is one cycle later.
- `busy` is registered state-derived: high in cycles where state≠IDLE.
- Simultaneous new request and last-byte transfer: the new request is not considered until IDLE.

## Configuration
- Macro: `UART_TX_ARB_TIMEOUT_EN`.
- **Defined:**
  - In GRANT, the stall counter increments each cycle `req_valid[g]`=0 and clears on any cycle `req_valid[g]`=1.
  - When it reaches `TIMEOUT_CYCLES`, go to IDLE (no gap) and pulse `timeout_err` for one cycle. `ptr` is already past g.
- **Undefined:** no stall counter. The grant is held indefinitely until `req_last` is transferred, and `timeout_err`=0.

## Test plan
- **Reset:** assert `rst` mid-GRANT with `tx_valid`=1 → same cycle `tx_valid`=0, `grant`=0, `busy`=0. After release, a request on req 2 gives `grant`=4'b0100 one cycle later.
- **Single packet:** req 1 sends 3 bytes 0xA5,0x5A,0xFF (last on 0xFF), with `tx_ready` pulsed 1 cycle every 40 cycles → `tx_data` matches in order, no other `req_ready` asserted, `busy` stays high 16 cycles after the 0xFF transfer.
- **Round-robin:** all four requesters each send 1-byte packets continuously → grant sequence 0,1,2,3,0, with 16-cycle gaps between grants.
- **No interleave:** req 0 in a 4-byte packet while req 3 asserts valid after byte 1 → req 3 is granted only after req 0's last byte plus the gap.
- **Zero gap:** `GAP_CYCLES`=0, two requesters valid → next grant two cycles after the last-byte transfer.
- **Timeout (macro defined, `TIMEOUT_CYCLES`=8):** req 1 sends 1 byte without last, then drops valid → `timeout_err` pulses after 8 stalled cycles, then req 2 pending is granted next cycle.
